synth_param_ctrl: RTL and testbench
===================================

// Module: synth_param_ctrl
//
// PURPOSE
//   Owns the synth's live settings: octave, amplitude, attack, decay, sustain and release.
//   Sits between the PS/2 key decoder and ALUcontroller, and drives the HEX displays.
//   Turns press/hold requests into saturating steps on the parameter selected by sel.
//   Held keys auto-repeat. The octave has its own pulse-driven saturating counter.
//
// PARAMETERS
//   STEP          8388608     amount added/removed per step (2^23)
//   MAX_VAL       1073741824  upper clamp for the 31-bit params (2^30)
//   OCT_MAX       7           octave upper clamp (lower clamp is 0)
//   REPEAT_DELAY  25000000    cycles held before the first auto-repeat (0.5 s @ 50 MHz)
//   REPEAT_RATE   5000000     cycles between auto-repeats (0.1 s @ 50 MHz)
//
// PORTS
//   clk         in   1   system clock (CLOCK_50)
//   reset       in   1   synchronous, active-low reset
//   inc_req     in   1   level; increment key held
//   dec_req     in   1   level; decrement key held
//   sel_next    in   1   1-cycle pulse; advance the parameter selector
//   oct_inc     in   1   1-cycle pulse; octave +1
//   oct_dec     in   1   1-cycle pulse; octave -1
//   sel         out  3   selected param: 0 amp, 1 attack, 2 decay, 3 sustain, 4 release
//   octave      out  3   current octave
//   amplitude   out  31  amplitude setting
//   attack      out  31  attack setting
//   decay       out  31  decay setting
//   sustain     out  31  sustain setting
//   rel         out  31  release setting
//   repeating   out  1   high while in state RPT
//
// BEHAVIOUR
// - Reset (reset==0 at a posedge, wins over all inputs):
//     octave=4, amplitude=attack=sustain=rel=MAX_VAL, decay=0, sel=0, state=IDLE, counter=0, repeating=0.
//   Reset mid-hold: go to IDLE. A key still held after reset counts as a new press.
// - All outputs are registered. An input sampled at edge k is visible after edge k (1-cycle latency).
// - dir = inc_req XOR dec_req; up = inc_req. Both high or both low means no request.
// - "Step" applies only to the parameter selected by sel:
//     up:   p = (p + STEP > MAX_VAL) ? MAX_VAL : p + STEP
//     down: p = (p < STEP) ? 0 : p - STEP
//   Compute in 32 bits so there is no wrap. Non-selected params hold their value.
// - FSM, with a 25-bit cycle counter cnt:
//     IDLE:  if dir, apply a step, cnt=0, latch the direction, go to DLY.
//     DLY:   if !dir or the direction changed, go to IDLE (no step).
//            Else if cnt==REPEAT_DELAY-1, apply a step, cnt=0, go to RPT. Else cnt++.
//     RPT:   same exit rule. If cnt==REPEAT_RATE-1, apply a step and set cnt=0. Else cnt++.
//   A direction flip while held goes to IDLE for one cycle, then counts as a fresh press.
// - sel_next: accepted only in IDLE. sel = (sel==4) ? 0 : sel+1. Dropped in DLY/RPT.
//   If sel_next and a new press land in the same IDLE cycle, the step applies to the OLD sel;
//   sel advances in the same cycle.
// - sel values 5-7 are never produced.
// - Octave: independent of the FSM and processed every cycle.
//     oct_inc only: octave = min(octave+1, OCT_MAX)
//     oct_dec only: octave = max(octave-1, 0)
//     both, or neither: no change
// - repeating = (state==RPT), registered.
//
// TESTING (bench uses REPEAT_DELAY=4, REPEAT_RATE=2, other parameters at default)
// - Reset check: after reset, octave=4, amp=attack=sustain=rel=1073741824, decay=0, sel=0.
// - Single press: sel=0, dec_req high for 1 cycle.
//   -> amplitude=1065353216 one cycle later; no further change.
// - Auto-repeat: sel=2, inc_req held 11 cycles.
//   -> decay steps at press +0, +4, +6, +8, +10, so decay=5*8388608=41943040.
//   -> repeating rises after the 2nd step.
// - Saturation: attack=MAX_VAL, inc_req pulsed -> stays 1073741824.
//   decay=0, dec_req pulsed -> stays 0.
// - Octave clamps: 4 oct_inc pulses -> 7 (clamped from 8).
//   oct_inc+oct_dec in the same cycle -> unchanged.
//   8 oct_dec pulses -> 0.
// - Conflicts:
//   - sel_next during RPT -> ignored.
//   - 5 sel_next pulses in IDLE -> sel returns to 0.
//   - inc_req and dec_req both high -> no change and state=IDLE.
//   - reset low during RPT -> all values return to defaults next cycle.

Source files
------------

// File: rtl/synth_param_ctrl.sv
// Live synth settings: saturating per-parameter steps with held-key auto-repeat,
// a wrapping parameter selector and an independent saturating octave counter.
module synth_param_ctrl #(
  parameter int unsigned STEP         = 8388608,
  parameter int unsigned MAX_VAL      = 1073741824,
  parameter int unsigned OCT_MAX      = 7,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_req,
  input  logic        dec_req,
  input  logic        sel_next,
  input  logic        oct_inc,
  input  logic        oct_dec,
  output logic [2:0]  sel,
  output logic [2:0]  octave,
  output logic [30:0] amplitude,
  output logic [30:0] attack,
  output logic [30:0] decay,
  output logic [30:0] sustain,
  output logic [30:0] rel,
  output logic        repeating
);

  localparam int unsigned PW    = 31;
  localparam int unsigned SW    = 3;
  localparam int unsigned CNT_W = 25;
  localparam int unsigned NPRM  = 5;
  localparam logic [PW-1:0] MAXV = PW'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, DLY, RPT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_up_q, dir_up_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [SW-1:0]     octave_q, octave_d;
  logic              repeating_q, repeating_d;
  logic [PW-1:0]     prm_q [NPRM];
  logic [PW-1:0]     prm_d [NPRM];
  logic              dir, do_step;
  logic [CNT_W-1:0]  lim;

  // Saturating step, computed in 32 bits so neither direction can wrap
  function automatic logic [PW-1:0] step_val(input logic [PW-1:0] p, input logic up);
    logic [31:0] sum;
    sum = 32'(p) + 32'(STEP);
    if (up) step_val = (sum > 32'(MAX_VAL)) ? MAXV : PW'(sum);
    else    step_val = (32'(p) < 32'(STEP)) ? '0 : PW'(32'(p) - 32'(STEP));
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    sel_d    = sel_q;
    octave_d = octave_q;
    prm_d    = prm_q;
    do_step  = 1'b0;
    dir      = inc_req ^ dec_req;
    lim      = (state_q == DLY) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1);

    case (state_q)
      IDLE: begin
        if (sel_next) sel_d = (sel_q == SW'(NPRM - 1)) ? '0 : sel_q + SW'(1);
        if (dir) begin
          do_step  = 1'b1;
          cnt_d    = '0;
          dir_up_d = inc_req;
          state_d  = DLY;
        end
      end
      DLY, RPT: begin
        // Release or direction flip drops back to IDLE; a flip re-presses next cycle
        if (!dir || (inc_req != dir_up_q)) begin
          state_d = IDLE;
        end else if (cnt_q == lim) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = RPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Step uses the pre-advance selector
    for (int i = 0; i < int'(NPRM); i++) begin
      if (do_step && (sel_q == SW'(i))) prm_d[i] = step_val(prm_q[i], dir_up_d);
    end

    if (oct_inc && !oct_dec && (octave_q < SW'(OCT_MAX))) octave_d = octave_q + SW'(1);
    if (oct_dec && !oct_inc && (octave_q != '0))          octave_d = octave_q - SW'(1);

    repeating_d = (state_d == RPT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_up_q    <= 1'b0;
      sel_q       <= '0;
      octave_q    <= SW'(4);
      repeating_q <= 1'b0;
      prm_q       <= '{MAXV, MAXV, '0, MAXV, MAXV};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_up_q    <= dir_up_d;
      sel_q       <= sel_d;
      octave_q    <= octave_d;
      repeating_q <= repeating_d;
      prm_q       <= prm_d;
    end
  end

  assign sel       = sel_q;
  assign octave    = octave_q;
  assign amplitude = prm_q[0];
  assign attack    = prm_q[1];
  assign decay     = prm_q[2];
  assign sustain   = prm_q[3];
  assign rel       = prm_q[4];
  assign repeating = repeating_q;

endmodule

// File: tb/tb_synth_param_ctrl.sv
// Bench for synth_param_ctrl: directed scenarios plus randomized traffic
// against a hold-duration reference model.
module tb_synth_param_ctrl;

  localparam int unsigned STEP = 8388608;
  localparam int unsigned MAXV = 1073741824;
  localparam int D = 4;
  localparam int R = 2;

  logic        clk, rst_n, inc, dec, seln, oi, od;
  logic [2:0]  sel, octave;
  logic [30:0] amplitude, attack, decay, sustain, rel;
  logic        repeating;
  logic [30:0] dut_prm [5];

  int checks = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_prm [5];
  int m_sel, m_oct, m_h;
  bit m_act, m_up, m_rpt;

  synth_param_ctrl #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .clk(clk), .reset(rst_n), .inc_req(inc), .dec_req(dec), .sel_next(seln),
    .oct_inc(oi), .oct_dec(od), .sel(sel), .octave(octave), .amplitude(amplitude),
    .attack(attack), .decay(decay), .sustain(sustain), .rel(rel), .repeating(repeating)
  );

  assign dut_prm[0] = amplitude;
  assign dut_prm[1] = attack;
  assign dut_prm[2] = decay;
  assign dut_prm[3] = sustain;
  assign dut_prm[4] = rel;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a press steps on its first cycle, then at hold ages D, D+R, D+2R, ...
  function automatic void model_update();
    bit dir, do_step;
    int idx;
    if (!rst_n) begin
      m_prm = '{MAXV, MAXV, 0, MAXV, MAXV};
      m_sel = 0; m_oct = 4; m_act = 0; m_h = 0; m_up = 0;
    end else begin
      dir = inc ^ dec;
      do_step = 0;
      idx = m_sel;
      if (!m_act) begin
        if (seln) m_sel = (m_sel + 1) % 5;
        if (dir) begin do_step = 1; m_act = 1; m_h = 0; m_up = inc; end
      end else if (!dir || (inc != m_up)) begin
        m_act = 0;
      end else begin
        m_h++;
        if (m_h == D || (m_h > D && ((m_h - D) % R) == 0)) do_step = 1;
      end
      if (do_step) begin
        if (m_up) m_prm[idx] = (m_prm[idx] + STEP > MAXV) ? MAXV : m_prm[idx] + STEP;
        else      m_prm[idx] = (m_prm[idx] < STEP) ? 0 : m_prm[idx] - STEP;
      end
      if (oi && !od && m_oct < 7) m_oct++;
      if (od && !oi && m_oct > 0) m_oct--;
    end
    m_rpt = m_act && (m_h >= D);
  endfunction

  task automatic cyc(input logic i, input logic d, input logic s, input logic a, input logic b);
    inc = i; dec = d; seln = s; oi = a; od = b;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1, 0, 1, 1, 0);
    rst_n = 1'b1;
    checks += 6;
    if (octave !== 3'd4) begin failures++; $display("FAIL reset_octave got=%0d exp=4", octave); end
    if (amplitude !== 31'd1073741824 || attack !== 31'd1073741824)
      begin failures++; $display("FAIL reset_amp_att got=%0d,%0d exp=1073741824", amplitude, attack); end
    if (sustain !== 31'd1073741824 || rel !== 31'd1073741824)
      begin failures++; $display("FAIL reset_sus_rel got=%0d,%0d exp=1073741824", sustain, rel); end
    if (decay !== 31'd0) begin failures++; $display("FAIL reset_decay got=%0d exp=0", decay); end
    if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    if (repeating !== 1'b0) begin failures++; $display("FAIL reset_repeating got=%0b exp=0", repeating); end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_single_press();
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (amplitude !== 31'd1065353216) begin failures++; $display("FAIL single_press got=%0d exp=1065353216", amplitude); end
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
    checks += 2;
    if (amplitude !== 31'd1065353216) begin failures++; $display("FAIL single_press_hold got=%0d exp=1065353216", amplitude); end
    if (attack !== 31'd1073741824) begin failures++; $display("FAIL single_press_other got=%0d exp=1073741824", attack); end
  endtask

  task automatic test_auto_repeat();
    int steps;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (sel !== 3'd2) begin failures++; $display("FAIL repeat_sel got=%0d exp=2", sel); end
    steps = 0;
    for (int k = 0; k <= 10; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (k == 0 || k == 4 || k == 6 || k == 8 || k == 10) steps++;
      checks += 2;
      if (decay !== 31'(steps * STEP)) begin failures++; $display("FAIL repeat_decay k=%0d got=%0d exp=%0d", k, decay, steps * STEP); end
      if (repeating !== (k >= 4)) begin failures++; $display("FAIL repeat_flag k=%0d got=%0b exp=%0b", k, repeating, k >= 4); end
    end
    cyc(0, 0, 0, 0, 0);
    checks += 2;
    if (decay !== 31'd41943040) begin failures++; $display("FAIL repeat_total got=%0d exp=41943040", decay); end
    if (repeating !== 1'b0) begin failures++; $display("FAIL repeat_release got=%0b exp=0", repeating); end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; cyc(0, 0, 0, 0, 0); rst_n = 1'b1;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (attack !== 31'd1073741824) begin failures++; $display("FAIL sat_attack got=%0d exp=1073741824", attack); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (decay !== 31'd0) begin failures++; $display("FAIL sat_decay got=%0d exp=0", decay); end
  endtask

  task automatic test_octave();
    int exp_o;
    exp_o = 4;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 0);
      exp_o = (exp_o + 1 > 7) ? 7 : exp_o + 1;
      checks++;
      if (octave !== 3'(exp_o)) begin failures++; $display("FAIL oct_inc k=%0d got=%0d exp=%0d", k, octave, exp_o); end
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 1);
    checks++;
    if (octave !== 3'd7) begin failures++; $display("FAIL oct_both got=%0d exp=7", octave); end
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 1);
      exp_o = (exp_o - 1 < 0) ? 0 : exp_o - 1;
      checks++;
      if (octave !== 3'(exp_o)) begin failures++; $display("FAIL oct_dec k=%0d got=%0d exp=%0d", k, octave, exp_o); end
    end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_conflicts();
    rst_n = 1'b0; cyc(0, 0, 0, 0, 0); rst_n = 1'b1;
    // sel_next while repeating is dropped
    for (int k = 0; k < 7; k++) cyc(0, 1, (k == 5), 0, 0);
    checks += 2;
    if (repeating !== 1'b1) begin failures++; $display("FAIL conf_in_rpt got=%0b exp=1", repeating); end
    if (sel !== 3'd0) begin failures++; $display("FAIL conf_sel_rpt got=%0d exp=0", sel); end
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 0, 0);
      checks++;
      if (sel !== 3'((k + 1) % 5)) begin failures++; $display("FAIL conf_sel_wrap k=%0d got=%0d exp=%0d", k, sel, (k + 1) % 5); end
    end
    // Both keys: no step and no repeat; a later single press steps at once
    rst_n = 1'b0; cyc(0, 0, 0, 0, 0); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cyc(1, 1, 0, 0, 0);
    checks += 2;
    if (amplitude !== 31'd1073741824) begin failures++; $display("FAIL conf_both_val got=%0d exp=1073741824", amplitude); end
    if (repeating !== 1'b0) begin failures++; $display("FAIL conf_both_rpt got=%0b exp=0", repeating); end
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (amplitude !== 31'd1065353216) begin failures++; $display("FAIL conf_both_idle got=%0d exp=1065353216", amplitude); end
    // Reset mid-repeat with the key still held
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0);
    rst_n = 1'b0;
    cyc(0, 1, 0, 1, 0);
    checks += 3;
    if (amplitude !== 31'd1073741824) begin failures++; $display("FAIL conf_rst_amp got=%0d exp=1073741824", amplitude); end
    if (repeating !== 1'b0) begin failures++; $display("FAIL conf_rst_rpt got=%0b exp=0", repeating); end
    if (octave !== 3'd4) begin failures++; $display("FAIL conf_rst_oct got=%0d exp=4", octave); end
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (amplitude !== 31'd1065353216) begin failures++; $display("FAIL conf_rst_repress got=%0d exp=1065353216", amplitude); end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] keys;
    keys = 2'b00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) keys = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(keys[0], keys[1], ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      checks += 3;
      if (sel !== 3'(m_sel)) begin failures++; $display("FAIL rand_sel n=%0d got=%0d exp=%0d", n, sel, m_sel); end
      if (octave !== 3'(m_oct)) begin failures++; $display("FAIL rand_oct n=%0d got=%0d exp=%0d", n, octave, m_oct); end
      if (repeating !== m_rpt) begin failures++; $display("FAIL rand_rpt n=%0d got=%0b exp=%0b", n, repeating, m_rpt); end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dut_prm[i] !== 31'(m_prm[i])) begin failures++; $display("FAIL rand_prm%0d n=%0d got=%0d exp=%0d", i, n, dut_prm[i], m_prm[i]); end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; inc = 0; dec = 0; seln = 0; oi = 0; od = 0;
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_saturation();
    test_octave();
    test_conflicts();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
